// File: rtl/dmem_resp.sv
// Data-memory responder: fixed-latency request/response with byte write strobes.
// Out-of-range or read+write requests answer with resp_err and no side effects.
module dmem_resp #(
    parameter int          DEPTH   = 512,
    parameter int          LATENCY = 2,
    parameter logic [63:0] BASE    = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        re,
    input  logic        we,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    input  logic [7:0]  wstrb,
    input  logic        core_ready,
    output logic        req_ready,
    output logic        data_valid,
    output logic [63:0] rdata,
    output logic        resp_err,
    output logic        busy
);
    // state | meaning
    // IDLE  | ready, accepts re|we
    // WAIT  | request latched, latency counter running down
    // RESP  | response presented, held until core_ready
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [63:0] SPAN     = 64'(DEPTH) * 64'd8;
    localparam logic [3:0]  CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    state_t        state;
    logic [3:0]    cnt;
    logic [63:0]   mem [DEPTH];

    logic          lat_re, lat_we, lat_err;
    logic [AW-1:0] lat_idx;
    logic [63:0]   lat_wdata;
    logic [7:0]    lat_wstrb;

    logic [63:0]   addr_off;
    logic          acc_err;
    logic [AW-1:0] acc_idx;

    logic          cur_re, cur_we, cur_err;
    logic [AW-1:0] cur_idx;
    logic [63:0]   cur_wdata;
    logic [7:0]    cur_wstrb;
    logic          go_resp, mem_wr;
    logic [63:0]   rd_val;

    assign addr_off = addr - BASE;
    assign acc_err  = (addr < BASE) || (addr_off >= SPAN) || (re && we);
    assign acc_idx  = addr_off[AW+2:3];

    // With LATENCY==1 the accept edge is also the RESP entry edge, so the live inputs apply.
    always_comb begin
        cur_re    = lat_re;
        cur_we    = lat_we;
        cur_err   = lat_err;
        cur_idx   = lat_idx;
        cur_wdata = lat_wdata;
        cur_wstrb = lat_wstrb;
        if (state == IDLE) begin
            cur_re    = re;
            cur_we    = we;
            cur_err   = acc_err;
            cur_idx   = acc_idx;
            cur_wdata = wdata;
            cur_wstrb = wstrb;
        end
    end

    assign go_resp = !rst && (((state == IDLE) && (re || we) && (LATENCY == 1)) ||
                              ((state == WAIT) && (cnt == 4'd0)));
    assign mem_wr  = go_resp && cur_we && !cur_err;
    assign rd_val  = (cur_re && !cur_err) ? mem[cur_idx] : 64'd0;

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int b = 0; b < 8; b++) begin
                if (cur_wstrb[b]) mem[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            data_valid <= 1'b0;
            rdata      <= 64'd0;
            resp_err   <= 1'b0;
            lat_re     <= 1'b0;
            lat_we     <= 1'b0;
            lat_err    <= 1'b0;
            lat_idx    <= '0;
            lat_wdata  <= 64'd0;
            lat_wstrb  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (re || we) begin
                        lat_re    <= re;
                        lat_we    <= we;
                        lat_err   <= acc_err;
                        lat_idx   <= acc_idx;
                        lat_wdata <= wdata;
                        lat_wstrb <= wstrb;
                        if (LATENCY == 1) begin
                            state      <= RESP;
                            data_valid <= 1'b1;
                            resp_err   <= cur_err;
                            rdata      <= rd_val;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state      <= RESP;
                        data_valid <= 1'b1;
                        resp_err   <= cur_err;
                        rdata      <= rd_val;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (core_ready) begin
                        state      <= IDLE;
                        data_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign busy      = ~req_ready;

endmodule
